// File: rtl/gate_truth_table_analyzer.sv
// Drives the four {a,b} vectors into an external 2-input gate and samples its output.
// Builds the 4-bit truth table and classifies it into a gate code.
module gate_truth_table_analyzer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       stim_a,
  output logic       stim_b,
  input  logic       dut_y,
  output logic [3:0] truth_table,
  output logic [2:0] gate_id,
  output logic       valid_match
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_idx;
  logic [1:0] w_idx_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [2:0] r_shadow;
  logic [2:0] w_shadow_nxt;
  logic       w_last_sample;

  logic       r_busy;
  logic       r_done;
  logic       r_stim_a;
  logic       r_stim_b;
  logic [3:0] r_tt;
  logic [2:0] r_id;
  logic       r_valid;

  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_stim_a_nxt;
  logic       w_stim_b_nxt;
  logic [3:0] w_tt_nxt;
  logic [2:0] w_id_nxt;
  logic       w_valid_nxt;

  // Map a truth table (bit i = y for {a,b}=i) to its gate code; 7 means unknown.
  function automatic logic [2:0] classify(input logic [3:0] tt);
    logic [2:0] id;
    case (tt)
      4'b1000: id = 3'd0;
      4'b1110: id = 3'd1;
      4'b0111: id = 3'd2;
      4'b0001: id = 3'd3;
      4'b0110: id = 3'd4;
      4'b1001: id = 3'd5;
      4'b0011: id = 3'd6;
      default: id = 3'd7;
    endcase
    return id;
  endfunction

  assign w_last_sample = (r_state == ST_SETTLE) && (r_cnt == 4'd0) && (r_idx == 2'd3);

  // State, vector index, settle counter and partial-table shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= 4'd0;
      r_shadow <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  // Next-state and sweep sequencing.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = CNT_RELOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // Vector 3 is never stored; it feeds the result directly on the last edge.
          for (int i = 0; i < 3; i++) begin
            if (r_idx == 2'(i)) begin
              w_shadow_nxt[i] = dut_y;
            end else begin
              w_shadow_nxt[i] = r_shadow[i];
            end
          end
          if (r_idx == 2'd3) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
            w_cnt_nxt = CNT_RELOAD;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs, derived from the upcoming state.
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_SETTLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
    if (w_state_nxt == ST_SETTLE) begin
      w_stim_a_nxt = w_idx_nxt[1];
      w_stim_b_nxt = w_idx_nxt[0];
    end else begin
      w_stim_a_nxt = 1'b0;
      w_stim_b_nxt = 1'b0;
    end
    if (w_last_sample) begin
      w_tt_nxt    = {dut_y, r_shadow};
      w_id_nxt    = classify(w_tt_nxt);
      w_valid_nxt = (w_id_nxt != 3'd7);
    end else begin
      w_tt_nxt    = r_tt;
      w_id_nxt    = r_id;
      w_valid_nxt = r_valid;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_stim_a <= 1'b0;
      r_stim_b <= 1'b0;
      r_tt     <= 4'b0000;
      r_id     <= 3'd7;
      r_valid  <= 1'b0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_stim_a <= w_stim_a_nxt;
      r_stim_b <= w_stim_b_nxt;
      r_tt     <= w_tt_nxt;
      r_id     <= w_id_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign stim_a      = r_stim_a;
  assign stim_b      = r_stim_b;
  assign truth_table = r_tt;
  assign gate_id     = r_id;
  assign valid_match = r_valid;

endmodule

// File: tb/tb_gate_truth_table_analyzer.sv
// Directed bench for gate_truth_table_analyzer: a modelled gate on a SETTLE_CYCLES=2
// instance and a NOR gate on a SETTLE_CYCLES=1 instance.
module tb_gate_truth_table_analyzer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, busy_a, done_a, stim_a_a, stim_b_a, y_a, valid_a;
  logic [3:0] tt_a;
  logic [2:0] id_a;
  logic       start_b, busy_b, done_b, stim_a_b, stim_b_b, y_b, valid_b;
  logic [3:0] tt_b;
  logic [2:0] id_b;
  logic [2:0] gmode;

  int checks = 0;
  int errors = 0;

  gate_truth_table_analyzer #(.SETTLE_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .stim_a(stim_a_a), .stim_b(stim_b_a), .dut_y(y_a),
    .truth_table(tt_a), .gate_id(id_a), .valid_match(valid_a)
  );

  gate_truth_table_analyzer #(.SETTLE_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .stim_a(stim_a_b), .stim_b(stim_b_b), .dut_y(y_b),
    .truth_table(tt_b), .gate_id(id_b), .valid_match(valid_b)
  );

  // Behavioural gate under test for instance A, selected by gmode.
  always_comb begin
    case (gmode)
      3'd0:    y_a = stim_a_a & stim_b_a;
      3'd2:    y_a = ~(stim_a_a & stim_b_a);
      3'd4:    y_a = stim_a_a ^ stim_b_a;
      3'd6:    y_a = ~stim_a_a;
      default: y_a = 1'b1;
    endcase
  end

  assign y_b = ~(stim_a_b | stim_b_b);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sweep_a(input string tag, input logic [3:0] exp_tt,
                         input logic [2:0] exp_id, input logic exp_v);
    int n;
    n = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check({tag, "_busy"}, 8'(busy_a), 8'd1);
    while (done_a !== 1'b1 && n < 20) begin
      if (n < 8) check({tag, "_stim"}, 8'({stim_a_a, stim_b_a}), 8'(n[2:1]));
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 8'(n), 8'd8);
    check({tag, "_tt"}, 8'(tt_a), 8'(exp_tt));
    check({tag, "_id"}, 8'(id_a), 8'(exp_id));
    check({tag, "_valid"}, 8'(valid_a), 8'(exp_v));
    check({tag, "_busy_done"}, 8'(busy_a), 8'd0);
    check({tag, "_stim_done"}, 8'({stim_a_a, stim_b_a}), 8'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 8'(done_a), 8'd0);
  endtask

  initial begin
    int n;
    int dcount;
    int first_k;
    int second_k;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    gmode   = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 8'(busy_a), 8'd0);
    check("rst_done", 8'(done_a), 8'd0);
    check("rst_stim", 8'({stim_a_a, stim_b_a}), 8'd0);
    check("rst_tt", 8'(tt_a), 8'd0);
    check("rst_id", 8'(id_a), 8'd7);
    check("rst_valid", 8'(valid_a), 8'd0);
    check("rst_id_b", 8'(id_b), 8'd7);
    rst_n = 1'b1;
    @(posedge clk); #1;

    gmode = 3'd0;
    sweep_a("and", 4'b1000, 3'd0, 1'b1);
    gmode = 3'd4;
    sweep_a("xor", 4'b0110, 3'd4, 1'b1);
    gmode = 3'd6;
    sweep_a("nota", 4'b0011, 3'd6, 1'b1);
    gmode = 3'd7;
    sweep_a("one", 4'b1111, 3'd7, 1'b0);

    // start held high: accepted at E0 and again at E10, dones after E8 and E18
    gmode    = 3'd0;
    dcount   = 0;
    first_k  = 0;
    second_k = 0;
    start_a  = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) begin
        dcount++;
        if (dcount == 1) first_k = k;
        else second_k = k;
      end
      check("held_id", 8'(id_a), (k >= 8) ? 8'd0 : 8'd7);
      if (k == 19) start_a = 1'b0;
    end
    check("held_count", 8'(dcount), 8'd2);
    check("held_first", 8'(first_k), 8'd8);
    check("held_second", 8'(second_k), 8'd18);
    @(posedge clk); #1;
    check("held_idle", 8'(busy_a), 8'd0);

    // reset three cycles into a NAND sweep
    gmode   = 3'd2;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_busy", 8'(busy_a), 8'd0);
    check("mid_stim", 8'({stim_a_a, stim_b_a}), 8'd0);
    check("mid_id", 8'(id_a), 8'd7);
    check("mid_tt", 8'(tt_a), 8'd0);
    check("mid_valid", 8'(valid_a), 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("mid_nodone", 8'(done_a), 8'd0);
    end
    sweep_a("nand", 4'b0111, 3'd2, 1'b1);

    // SETTLE_CYCLES=1 instance with a NOR gate
    n = 0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    while (done_b !== 1'b1 && n < 20) begin
      if (n < 4) check("nor_stim", 8'({stim_a_b, stim_b_b}), 8'(n[1:0]));
      @(posedge clk); #1;
      n++;
    end
    check("nor_latency", 8'(n), 8'd4);
    check("nor_tt", 8'(tt_b), 8'd1);
    check("nor_id", 8'(id_b), 8'd3);
    check("nor_valid", 8'(valid_b), 8'd1);
    check("nor_busy", 8'(busy_b), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
